// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: stage register fields in, stall/flush/forward controls out.
// The pipeline datapath is the master; the hazard unit is the slave.
interface hazard_ctrl_if;
    logic [4:0] RsD, RtD, RsE, RtE;
    logic [4:0] WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemReadE, MemReadM;
    logic [1:0] BranchD;
    logic       JumpSrcD;
    logic       DivStartE;
    logic       ExceptM;

    logic       StallF, StallD, StallE;
    logic       FlushD, FlushE, FlushM, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD;
    logic       DivBusy, DivDoneE;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM,
               BranchD, JumpSrcD, DivStartE, ExceptM,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM, FlushW,
               ForwardAE, ForwardBE, ForwardAD, ForwardBD, DivBusy, DivDoneE
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM,
               BranchD, JumpSrcD, DivStartE, ExceptM,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM, FlushW,
               ForwardAE, ForwardBE, ForwardAD, ForwardBD, DivBusy, DivDoneE
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS core: forwarding selects, load-use/branch stalls,
// multi-cycle divider stall FSM and the exception redirect flush.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_e;

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    divState_e        divState, divStateNext;
    logic [CNT_W-1:0] divCnt, divCntNext;

    logic lwStall, brStall, divStall;
    logic brUsesRs, brUsesRt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divState <= IDLE;
            divCnt   <= '0;
        end else begin
            divState <= divStateNext;
            divCnt   <= divCntNext;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        divStateNext = divState;
        divCntNext   = divCnt;
        if (hz.ExceptM) begin
            // The redirect squashes the div sitting in E, so the divide is abandoned.
            divStateNext = IDLE;
            divCntNext   = '0;
        end else begin
            unique case (divState)
                IDLE: if (hz.DivStartE) begin
                    divStateNext = BUSY;
                    divCntNext   = DIV_LOAD;
                end
                BUSY: if (divCnt != '0) begin
                    divCntNext = divCnt - CNT_W'(1);
                end else begin
                    divStateNext = DONE;
                end
                DONE:    divStateNext = IDLE;
                default: divStateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        divStall = (divState == IDLE && hz.DivStartE) || (divState == BUSY);

        lwStall = hz.MemReadE && hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
                  (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD);

        // jr/jalr only reads Rs in D; branches compare both operands.
        brUsesRs = (hz.BranchD != 2'b00) || hz.JumpSrcD;
        brUsesRt = (hz.BranchD != 2'b00);
        brStall  = 1'b0;
        if (hz.RegWriteE && hz.WriteRegE != 5'd0 &&
            ((brUsesRs && hz.WriteRegE == hz.RsD) || (brUsesRt && hz.WriteRegE == hz.RtD)))
            brStall = 1'b1;
        if (hz.MemReadM && hz.WriteRegM != 5'd0 &&
            ((brUsesRs && hz.WriteRegM == hz.RsD) || (brUsesRt && hz.WriteRegM == hz.RtD)))
            brStall = 1'b1;
    end

    always_comb begin
        hz.ForwardAE = 2'b00;
        if (hz.RegWriteM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RsE)
            hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && hz.WriteRegW != 5'd0 && hz.WriteRegW == hz.RsE)
            hz.ForwardAE = 2'b01;

        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RtE)
            hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && hz.WriteRegW != 5'd0 && hz.WriteRegW == hz.RtE)
            hz.ForwardBE = 2'b01;

        hz.ForwardAD = hz.RegWriteM && (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RsD);
        hz.ForwardBD = hz.RegWriteM && (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RtD);
    end

    always_comb begin
        hz.StallF   = 1'b0;
        hz.StallD   = 1'b0;
        hz.StallE   = 1'b0;
        hz.FlushD   = 1'b0;
        hz.FlushE   = 1'b0;
        hz.FlushM   = 1'b0;
        hz.FlushW   = 1'b0;
        hz.DivBusy  = (divState != IDLE);
        hz.DivDoneE = (divState == DONE);

        if (hz.ExceptM) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
            hz.FlushM = 1'b1;
            hz.FlushW = 1'b1;
        end else if (divStall) begin
            // The div is held in E, so M receives a bubble each stalled cycle.
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.FlushM = 1'b1;
        end else if (lwStall || brStall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
        end
    end

endmodule
